// File: rtl/mips_ctr_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM state
// codes and the ALU / datapath select encodings.
package mips_ctr_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  // State codes are visible on the debug port, so they are fixed explicitly.
  typedef enum logic [3:0] {
    StStart  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StAddiEx = 4'd11,
    StAddiWb = 4'd12,
    StTrap   = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    SrcBRegB   = 2'b00,
    SrcBFour   = 2'b01,
    SrcBImm    = 2'b10,
    SrcBImmSh2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PcSrcAlu    = 2'b00,
    PcSrcAluOut = 2'b01,
    PcSrcJump   = 2'b10
  } pc_source_t;

  function automatic logic is_legal_op(logic [5:0] op);
    return (op == OpRtype) || (op == OpLw) || (op == OpSw) ||
           (op == OpBeq) || (op == OpJ) || (op == OpAddi);
  endfunction

endpackage

// File: rtl/multicycle_ctr_decode.sv
// Combinational output decode for the multi-cycle controller.
// MULTICYCLE_CTR_TRAP_EN: illegal opcodes trap (TRAP raises illegalOp);
// otherwise an illegal opcode completes as a NOP in DECODE.
module multicycle_ctr_decode
  import mips_ctr_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_mem_ready,
`ifndef MULTICYCLE_CTR_TRAP_EN
  input  logic [5:0] i_op_code,
`endif
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_ior_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_aluop,
  output logic [1:0] o_pc_source,
  output logic       o_instr_done,
  output logic       o_illegal_op
);

  // Per-state strobes; anything not set in a state stays 0.
  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_ior_d         = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_dst       = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = SrcBRegB;
    o_aluop         = AluOpAdd;
    o_pc_source     = PcSrcAlu;
    o_instr_done    = 1'b0;
    o_illegal_op    = 1'b0;
    unique case (i_state)
      StFetch: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = SrcBFour;
        // Latch IR and bump PC only on the cycle the fetch completes.
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      StDecode: begin
        o_alu_src_b = SrcBImmSh2;
`ifndef MULTICYCLE_CTR_TRAP_EN
        o_instr_done = ~is_legal_op(i_op_code);
`endif
      end
      StMemAdr: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SrcBImm;
      end
      StMemRd: begin
        o_mem_read = 1'b1;
        o_ior_d    = 1'b1;
      end
      StMemWb: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        o_instr_done = 1'b1;
      end
      StMemWr: begin
        o_mem_write  = 1'b1;
        o_ior_d      = 1'b1;
        o_instr_done = i_mem_ready;
      end
      StExec: begin
        o_alu_src_a = 1'b1;
        o_aluop     = AluOpFunct;
      end
      StAluWb: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = 1'b1;
        o_instr_done = 1'b1;
      end
      StBranch: begin
        o_alu_src_a     = 1'b1;
        o_aluop         = AluOpSub;
        o_pc_source     = PcSrcAluOut;
        o_pc_write_cond = 1'b1;
        o_instr_done    = 1'b1;
      end
      StJump: begin
        o_pc_source  = PcSrcJump;
        o_pc_write   = 1'b1;
        o_instr_done = 1'b1;
      end
      StAddiEx: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SrcBImm;
      end
      StAddiWb: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end
      StTrap: begin
`ifdef MULTICYCLE_CTR_TRAP_EN
        o_illegal_op = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctr.sv
// Multi-cycle MIPS main controller: state register and next-state logic.
// MULTICYCLE_CTR_TRAP_EN: illegal opcodes enter TRAP until reset; otherwise
// they are treated as NOPs.
module multicycle_ctr
  import mips_ctr_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluop,
  output logic [1:0] pcSource,
  output logic       instrDone,
  output logic [3:0] state,
  output logic       illegalOp
);

  state_t r_state;
  state_t w_state_next;

  // Next-state: memory states hold until memReady, opCode read in DECODE/MEMADR.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StStart:  w_state_next = StFetch;
      StFetch:  if (memReady) w_state_next = StDecode;
      StDecode: begin
        unique case (opCode)
          OpLw, OpSw: w_state_next = StMemAdr;
          OpRtype:    w_state_next = StExec;
          OpBeq:      w_state_next = StBranch;
          OpJ:        w_state_next = StJump;
          OpAddi:     w_state_next = StAddiEx;
`ifdef MULTICYCLE_CTR_TRAP_EN
          default:    w_state_next = StTrap;
`else
          default:    w_state_next = StFetch;
`endif
        endcase
      end
      StMemAdr: w_state_next = (opCode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (memReady) w_state_next = StMemWb;
      StMemWr:  if (memReady) w_state_next = StFetch;
      StExec:   w_state_next = StAluWb;
      StAddiEx: w_state_next = StAddiWb;
      StMemWb, StAluWb, StBranch, StJump, StAddiWb: w_state_next = StFetch;
`ifdef MULTICYCLE_CTR_TRAP_EN
      StTrap:   w_state_next = StTrap;
`else
      StTrap:   w_state_next = StStart;
`endif
      default:  w_state_next = StStart;
    endcase
  end

  // State register; async reset abandons any in-flight memory access at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StStart;
    else       r_state <= w_state_next;
  end

  assign state = r_state;

  multicycle_ctr_decode u_decode (
    .i_state         (r_state),
    .i_mem_ready     (memReady),
`ifndef MULTICYCLE_CTR_TRAP_EN
    .i_op_code       (opCode),
`endif
    .o_pc_write      (pcWrite),
    .o_pc_write_cond (pcWriteCond),
    .o_ior_d         (iorD),
    .o_mem_read      (memRead),
    .o_mem_write     (memWrite),
    .o_ir_write      (irWrite),
    .o_mem_to_reg    (memToReg),
    .o_reg_dst       (regDst),
    .o_reg_write     (regWrite),
    .o_alu_src_a     (aluSrcA),
    .o_alu_src_b     (aluSrcB),
    .o_aluop         (aluop),
    .o_pc_source     (pcSource),
    .o_instr_done    (instrDone),
    .o_illegal_op    (illegalOp)
  );

endmodule

// File: tb/tb_multicycle_ctr.sv
// Randomized self-checking bench for multicycle_ctr. Each instruction is
// expanded into its expected per-cycle state list (with memory wait cycles)
// and the cycles-to-instrDone is checked against the per-opcode cycle count.
module tb_multicycle_ctr;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opCode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA, instrDone, illegalOp;
  logic [1:0] aluSrcB, aluop, pcSource;
  logic [3:0] state;

  multicycle_ctr dut (
    .clk         (clk),
    .reset       (reset),
    .opCode      (opCode),
    .memReady    (memReady),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .iorD        (iorD),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .irWrite     (irWrite),
    .memToReg    (memToReg),
    .regDst      (regDst),
    .regWrite    (regWrite),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluop       (aluop),
    .pcSource    (pcSource),
    .instrDone   (instrDone),
    .state       (state),
    .illegalOp   (illegalOp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    int st;
    bit mr;
  } step_t;

  localparam logic [5:0] Lw = 6'b100011, Sw = 6'b101011, Rt = 6'b000000;
  localparam logic [5:0] Beq = 6'b000100, Jmp = 6'b000010, Addi = 6'b001000;
  localparam logic [5:0] Ill = 6'b110000;

  int n_checks = 0;
  int n_fails  = 0;

  ctl_t got_ctl;
  assign got_ctl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                    regDst, regWrite, aluSrcA, aluSrcB, aluop, pcSource, instrDone,
                    illegalOp};

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(logic [5:0] op);
    return op inside {Lw, Sw, Rt, Beq, Jmp, Addi};
  endfunction

  // Expected datapath controls straight from the per-state output list.
  function automatic ctl_t exp_ctl(int st, bit mr, bit op_illegal);
    ctl_t c = '0;
    case (st)
      1:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      2:  begin
            c.alu_src_b = 2'b11;
`ifndef MULTICYCLE_CTR_TRAP_EN
            c.instr_done = op_illegal;
`endif
          end
      3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4:  begin c.mem_read = 1; c.ior_d = 1; end
      5:  begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      6:  begin c.mem_write = 1; c.ior_d = 1; c.instr_done = mr; end
      7:  begin c.alu_src_a = 1; c.aluop = 2'b10; end
      8:  begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
      9:  begin
            c.alu_src_a = 1; c.aluop = 2'b01; c.pc_source = 2'b01;
            c.pc_write_cond = 1; c.instr_done = 1;
          end
      10: begin c.pc_source = 2'b10; c.pc_write = 1; c.instr_done = 1; end
      11: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      12: begin c.reg_write = 1; c.instr_done = 1; end
      13: c.illegal_op = 1;
      default: ;
    endcase
    return c;
  endfunction

  // Run one instruction from FETCH entry: wf fetch waits, wm data-memory waits.
  // max_steps > 0 stops early (used to interrupt an access with reset).
  task automatic run_instr(string name, logic [5:0] op, int wf, int wm, int max_steps);
    step_t q[$];
    int    base;
    int    done_at = -1;
    bit    mem_op = 0;
    bit    trap = 0;
    bit    ill = !legal(op);
    for (int i = 0; i < wf; i++) q.push_back('{1, 1'b0});
    q.push_back('{1, 1'b1});
    q.push_back('{2, 1'($urandom)});
    case (op)
      Lw: begin
        base = 5; mem_op = 1;
        q.push_back('{3, 1'($urandom)});
        for (int i = 0; i < wm; i++) q.push_back('{4, 1'b0});
        q.push_back('{4, 1'b1});
        q.push_back('{5, 1'($urandom)});
      end
      Sw: begin
        base = 4; mem_op = 1;
        q.push_back('{3, 1'($urandom)});
        for (int i = 0; i < wm; i++) q.push_back('{6, 1'b0});
        q.push_back('{6, 1'b1});
      end
      Rt:   begin base = 4; q.push_back('{7, 1'($urandom)}); q.push_back('{8, 1'($urandom)}); end
      Addi: begin base = 4; q.push_back('{11, 1'($urandom)}); q.push_back('{12, 1'($urandom)}); end
      Beq:  begin base = 3; q.push_back('{9, 1'($urandom)}); end
      Jmp:  begin base = 3; q.push_back('{10, 1'($urandom)}); end
      default: begin
        base = 2;
`ifdef MULTICYCLE_CTR_TRAP_EN
        trap = 1;
        for (int i = 0; i < 12; i++) q.push_back('{13, 1'($urandom)});
`endif
      end
    endcase
    foreach (q[i]) begin
      if (max_steps == 0 || i < max_steps) begin
        @(negedge clk);
        // opCode only matters in DECODE/MEMADR; scramble it elsewhere.
        opCode   = (q[i].st == 2 || q[i].st == 3) ? op : 6'($urandom);
        memReady = q[i].mr;
        #1;
        check($sformatf("%s[%0d] state", name, i), 32'(state), 32'(q[i].st));
        check($sformatf("%s[%0d] ctl", name, i), 32'(got_ctl),
              32'(exp_ctl(q[i].st, q[i].mr, ill)));
        if (instrDone && done_at < 0) done_at = i + 1;
      end
    end
    if (max_steps == 0 && !trap)
      check($sformatf("%s cycles", name), 32'(done_at),
            32'(base + wf + (mem_op ? wm : 0)));
  endtask

  logic [5:0] ops[6] = '{Lw, Sw, Rt, Beq, Jmp, Addi};

  initial begin
    reset    = 1'b1;
    memReady = 1'b0;
    opCode   = 6'd0;
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset ctl", 32'(got_ctl), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("start state", 32'(state), 32'd0);
    check("start ctl", 32'(got_ctl), 32'd0);

    run_instr("lw", Lw, 0, 0, 0);
    run_instr("sw_wait", Sw, 0, 3, 0);
    run_instr("r_fwait", Rt, 2, 0, 0);
    run_instr("beq", Beq, 0, 0, 0);
    run_instr("j", Jmp, 0, 0, 0);
    run_instr("addi", Addi, 1, 0, 0);
`ifndef MULTICYCLE_CTR_TRAP_EN
    run_instr("ill_nop", Ill, 0, 0, 0);
`endif

    // Reset while MEMRD is waiting on memory.
    run_instr("lw_cut", Lw, 0, 5, 4);
    #1 reset = 1'b1;
    #1;
    check("async state", 32'(state), 32'd0);
    check("async memRead", 32'(memRead), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-reset start", 32'(state), 32'd0);
    run_instr("r_after_rst", Rt, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(5)];
`ifndef MULTICYCLE_CTR_TRAP_EN
      if ($urandom_range(7) == 0) begin
        do op = 6'($urandom_range(63)); while (legal(op));
      end
`endif
      run_instr($sformatf("rnd%0d_%b", n, op), op, $urandom_range(3), $urandom_range(3), 0);
    end

`ifdef MULTICYCLE_CTR_TRAP_EN
    run_instr("ill_trap", Ill, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
